// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: turns RV32I loads/stores into word-aligned memory transactions.
//   A request may cross a word boundary. It is then issued as two word
//   transactions, or rejected with err when ALLOW_MISALIGNED=0.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   req/req_ready     request handshake (accepted only in IDLE)
//   req_we/req_funct3/req_addr/req_wdata  access descriptor
//   done/rdata/err    completion pulse, extended load data, error flag
//   mem_*             word-aligned memory port, strobes held until mem_resp
module mem_access_ctrl #(
  parameter logic ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;
  state_t state, state_nx;

  logic        we_q, cross_q, err_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q, rdata0_q;

  logic [2:0]  req_size;
  logic        req_legal, req_cross, req_bad;
  logic        resp_ok;
  logic [2:0]  hi_sh;

  function automatic logic [3:0] bmask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   bmask = 4'h1;
      2'b01:   bmask = 4'h3;
      default: bmask = 4'hF;
    endcase
  endfunction

  function automatic logic [3:0] be_lo(input logic [2:0] f3, input logic [1:0] o);
    logic [7:0] t;
    t = {4'b0, bmask(f3)} << o;
    be_lo = t[3:0];
  endfunction

  // Shift the two captured words down to the access offset, then truncate and extend.
  function automatic logic [31:0] ext_load(input logic [63:0] w, input logic [1:0] o,
                                           input logic [2:0] f3);
    logic [63:0] s;
    s = w >> {o, 3'b000};
    case (f3[1:0])
      2'b00:   ext_load = f3[2] ? {24'b0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
      2'b01:   ext_load = f3[2] ? {16'b0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: ext_load = s[31:0];
    endcase
  endfunction

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   req_size = 3'd1;
      2'b01:   req_size = 3'd2;
      default: req_size = 3'd4;
    endcase
    req_legal = (req_funct3 inside {3'b000, 3'b001, 3'b010}) ||
                (!req_we && (req_funct3 inside {3'b100, 3'b101}));
    req_cross = ({1'b0, req_addr[1:0]} + req_size) > 3'd4;
    req_bad   = !req_legal || (req_cross && !ALLOW_MISALIGNED);
  end

  // A response only counts while a strobe is actually out; this also covers
  // the idle cycle at the start of ACC1 before its strobe rises.
  assign resp_ok = mem_resp && (mem_read || mem_write);
  assign hi_sh   = 3'd4 - {1'b0, off_q};

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = req_bad ? DONE : ACC0;
      ACC0:    if (resp_ok) state_nx = cross_q ? ACC1 : DONE;
      ACC1:    if (resp_ok) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    req_ready = (state == IDLE);
    done      = (state == DONE);
    err       = (state == DONE) && err_q;
  end

  // Datapath and registered memory-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q <= 1'b0; cross_q <= 1'b0; err_q <= 1'b0;
      f3_q <= 3'b0; off_q <= 2'b0; wdata_q <= 32'b0; rdata0_q <= 32'b0;
      rdata <= 32'b0;
      mem_read <= 1'b0; mem_write <= 1'b0;
      mem_address <= 32'b0; mem_byte_enable <= 4'b0; mem_wdata <= 32'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          we_q    <= req_we;
          f3_q    <= req_funct3;
          off_q   <= req_addr[1:0];
          cross_q <= req_cross;
          wdata_q <= req_wdata;
          if (req_bad) begin
            err_q <= 1'b1;
            rdata <= 32'b0;
          end else begin
            err_q           <= 1'b0;
            mem_read        <= !req_we;
            mem_write       <= req_we;
            mem_address     <= {req_addr[31:2], 2'b00};
            mem_byte_enable <= req_we ? be_lo(req_funct3, req_addr[1:0]) : 4'hF;
            mem_wdata       <= req_wdata << {req_addr[1:0], 3'b000};
          end
        end
        ACC0: if (resp_ok) begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          rdata0_q  <= mem_rdata;
          if (cross_q) begin
            // second word: address wraps naturally at 2^32
            mem_address     <= mem_address + 32'd4;
            mem_byte_enable <= we_q ? (bmask(f3_q) >> hi_sh) : 4'hF;
            mem_wdata       <= wdata_q >> {hi_sh, 3'b000};
          end else begin
            rdata <= we_q ? 32'b0 : ext_load({32'b0, mem_rdata}, off_q, f3_q);
          end
        end
        ACC1: begin
          if (resp_ok) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rdata     <= we_q ? 32'b0 : ext_load({mem_rdata, rdata0_q}, off_q, f3_q);
          end else if (!mem_read && !mem_write) begin
            mem_read  <= !we_q;
            mem_write <= we_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
